// File: rtl/tristate_bus_ctrl_if.sv
// Requester-side signal bundle for tristate_bus_ctrl.
// The shared three-state net stays a direct inout port on the controller.
interface tristate_bus_ctrl_if #(
    parameter int WIDTH = 8,
    parameter int NCH   = 4
);
    logic [NCH-1:0]       req;
    logic [NCH*WIDTH-1:0] data_in;
    logic [NCH-1:0]       grant;
    logic                 oe;
    logic [WIDTH-1:0]     bus_q;

    modport master (output req, output data_in, input grant, input oe, input bus_q);
    modport slave  (input req, input data_in, output grant, output oe, output bus_q);
endinterface

// File: rtl/tristate_bus_ctrl.sv
// Round-robin arbiter that drives one shared WIDTH-bit three-state bus from a
// register on behalf of NCH requesting channels, releasing it to 'z when idle.
// Optional macro BUS_TURNAROUND_EN inserts a one-cycle released (TURN) cycle
// between consecutive drive windows; without it, handoff is DRIVE -> DRIVE.
module tristate_bus_ctrl #(
    parameter int WIDTH     = 8,
    parameter int NCH       = 4,
    parameter int MAX_BURST = 4
) (
    input  logic               clk,
    input  logic               rst,
    tristate_bus_ctrl_if.slave ctrl_if,
    inout  wire  [WIDTH-1:0]   bus
);
    localparam int PTR_W = (NCH > 1) ? $clog2(NCH) : 1;
    localparam int CNT_W = $clog2(MAX_BURST + 1);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_DRIVE = 2'd1;
    localparam logic [1:0] S_TURN  = 2'd2;

    logic [1:0]       state_q, state_d;
    logic [NCH-1:0]   grant_q, grant_d;
    logic             oe_q, oe_d;
    logic [WIDTH-1:0] dreg_q, dreg_d;
    logic [WIDTH-1:0] busq_q;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [PTR_W-1:0] ptr_q, ptr_d;
    logic [PTR_W-1:0] owner_q, owner_d;

    logic [PTR_W-1:0] nxt_ptr;
    logic [PTR_W-1:0] arb_base;
    logic [PTR_W-1:0] win;
    logic [WIDTH-1:0] win_data;
    logic [WIDTH-1:0] own_data;
    logic             any_req;
    logic             leave;

    // First requester at or after base, cyclically; only meaningful when |r.
    function automatic logic [PTR_W-1:0] rr_pick(input logic [NCH-1:0] r,
                                                 input logic [PTR_W-1:0] base);
        logic [PTR_W-1:0] w;
        int idx;
        w = base;
        for (int k = NCH - 1; k >= 0; k--) begin
            idx = (int'(base) + k) % NCH;
            if (r[idx]) w = PTR_W'(idx);
        end
        return w;
    endfunction

    // On handoff the arbitration already uses the rotated pointer, so the
    // outgoing owner ranks last and is re-granted only without competitors.
    always_comb begin
        nxt_ptr  = (owner_q == PTR_W'(NCH - 1)) ? '0 : owner_q + 1'b1;
        arb_base = (state_q == S_DRIVE) ? nxt_ptr : ptr_q;
        any_req  = |ctrl_if.req;
        win      = rr_pick(ctrl_if.req, arb_base);
        win_data = ctrl_if.data_in[int'(win) * WIDTH +: WIDTH];
        own_data = ctrl_if.data_in[int'(owner_q) * WIDTH +: WIDTH];
        leave    = !ctrl_if.req[owner_q] || (cnt_q == CNT_W'(MAX_BURST - 1));
    end

    // Next-state logic: arbitration in IDLE/TURN, burst accounting in DRIVE.
    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        oe_d    = oe_q;
        dreg_d  = dreg_q;
        cnt_d   = cnt_q;
        ptr_d   = ptr_q;
        owner_d = owner_q;
        case (state_q)
            S_IDLE, S_TURN: begin
                cnt_d = '0;
                if (any_req) begin
                    state_d      = S_DRIVE;
                    grant_d      = '0;
                    grant_d[win] = 1'b1;
                    oe_d         = 1'b1;
                    owner_d      = win;
                    dreg_d       = win_data;
                end else begin
                    state_d = S_IDLE;
                    grant_d = '0;
                    oe_d    = 1'b0;
                end
            end
            S_DRIVE: begin
                if (!leave) begin
                    dreg_d = own_data;
                    cnt_d  = cnt_q + 1'b1;
                end else begin
                    ptr_d = nxt_ptr;
                    cnt_d = '0;
`ifdef BUS_TURNAROUND_EN
                    state_d = S_TURN;
                    grant_d = '0;
                    oe_d    = 1'b0;
`else
                    if (any_req) begin
                        state_d      = S_DRIVE;
                        grant_d      = '0;
                        grant_d[win] = 1'b1;
                        oe_d         = 1'b1;
                        owner_d      = win;
                        dreg_d       = win_data;
                    end else begin
                        state_d = S_IDLE;
                        grant_d = '0;
                        oe_d    = 1'b0;
                    end
`endif
                end
            end
            default: begin
                state_d = S_IDLE;
                grant_d = '0;
                oe_d    = 1'b0;
                cnt_d   = '0;
            end
        endcase
    end

    // State registers; reset is asynchronous so the bus releases immediately.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            grant_q <= '0;
            oe_q    <= 1'b0;
            dreg_q  <= '0;
            cnt_q   <= '0;
            ptr_q   <= '0;
            owner_q <= '0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            oe_q    <= oe_d;
            dreg_q  <= dreg_d;
            cnt_q   <= cnt_d;
            ptr_q   <= ptr_d;
            owner_q <= owner_d;
        end
    end

    // Sample the resolved net every edge, including foreign drivers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) busq_q <= '0;
        else     busq_q <= bus;
    end

    assign bus           = oe_q ? dreg_q : {WIDTH{1'bz}};
    assign ctrl_if.grant = grant_q;
    assign ctrl_if.oe    = oe_q;
    assign ctrl_if.bus_q = busq_q;

endmodule

// File: tb/tb_tristate_bus_ctrl.sv
// Self-checking bench for tristate_bus_ctrl: directed scenarios plus random
// request traffic compared against a transaction-level ownership model.
module tb_tristate_bus_ctrl;
    localparam int WIDTH     = 8;
    localparam int NCH       = 4;
    localparam int MAX_BURST = 4;

    logic             clk;
    logic             rst;
    logic             ext_en;
    logic [WIDTH-1:0] ext_val;
    wire  [WIDTH-1:0] bus;

    int n_chk;
    int n_fail;

    // Model state: current owner (-1 = nobody driving), pointer, cycles used.
    int               m_owner;
    int               m_ptr;
    int               m_cnt;
    logic [WIDTH-1:0] m_dreg;

    tristate_bus_ctrl_if #(.WIDTH(WIDTH), .NCH(NCH)) ifc ();

    tristate_bus_ctrl #(.WIDTH(WIDTH), .NCH(NCH), .MAX_BURST(MAX_BURST)) dut (
        .clk     (clk),
        .rst     (rst),
        .ctrl_if (ifc),
        .bus     (bus)
    );

    assign bus = ext_en ? ext_val : {WIDTH{1'bz}};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
        end
    endtask

    function automatic int pick(input logic [NCH-1:0] r, input int base);
        for (int k = 0; k < NCH; k++)
            if (r[(base + k) % NCH]) return (base + k) % NCH;
        return -1;
    endfunction

    task automatic model_reset();
        m_owner = -1;
        m_ptr   = 0;
        m_cnt   = 0;
        m_dreg  = '0;
    endtask

    // One clock edge of the ownership rules.
    task automatic model_step(input logic [NCH-1:0] r, input logic [NCH*WIDTH-1:0] d);
        int w;
        if (m_owner < 0) begin
            w = pick(r, m_ptr);
            if (w >= 0) begin
                m_owner = w;
                m_cnt   = 0;
                m_dreg  = d[w*WIDTH +: WIDTH];
            end
        end else if (r[m_owner] && m_cnt < MAX_BURST - 1) begin
            m_cnt++;
            m_dreg = d[m_owner*WIDTH +: WIDTH];
        end else begin
            m_ptr = (m_owner + 1) % NCH;
            m_cnt = 0;
`ifdef BUS_TURNAROUND_EN
            m_owner = -1;
`else
            w = pick(r, m_ptr);
            m_owner = w;
            if (w >= 0) m_dreg = d[w*WIDTH +: WIDTH];
`endif
        end
    endtask

    // Apply inputs at the falling edge, advance one rising edge, compare.
    task automatic cyc(input logic [NCH-1:0] r, input logic [NCH*WIDTH-1:0] d,
                       input logic xe, input logic [WIDTH-1:0] xv);
        logic             pre_known;
        logic [WIDTH-1:0] pre_val;
        logic [NCH-1:0]   exp_g;
        @(negedge clk);
        ifc.req     = r;
        ifc.data_in = d;
        ext_en      = xe;
        ext_val     = xv;
        pre_known   = (m_owner >= 0) || xe;
        pre_val     = (m_owner >= 0) ? m_dreg : xv;
        model_step(r, d);
        @(posedge clk);
        #1;
        exp_g = '0;
        if (m_owner >= 0) exp_g[m_owner] = 1'b1;
        check_eq("grant", 32'(ifc.grant), 32'(exp_g));
        check_eq("oe", 32'(ifc.oe), 32'(m_owner >= 0));
        check_eq("onehot", 32'($countones(ifc.grant) <= 1), 32'd1);
        if (m_owner >= 0)  check_eq("bus", 32'(bus), 32'(m_dreg));
        else if (xe)       check_eq("bus_ext", 32'(bus), 32'(xv));
        if (pre_known)     check_eq("bus_q", 32'(ifc.bus_q), 32'(pre_val));
    endtask

    // Asynchronous reset asserted between edges; outputs must clear at once.
    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        #1;
        check_eq("rst_grant", 32'(ifc.grant), 32'd0);
        check_eq("rst_oe", 32'(ifc.oe), 32'd0);
        check_eq("rst_bus_q", 32'(ifc.bus_q), 32'd0);
        ifc.req = '0;
        ext_en  = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        model_reset();
    endtask

    initial begin
        logic [NCH-1:0]       r;
        logic [NCH-1:0]       prev_r;
        logic [NCH*WIDTH-1:0] d;
        logic [NCH-1:0]       exp_g;
        logic                 xe;
        logic [WIDTH-1:0]     xv;
        n_chk       = 0;
        n_fail      = 0;
        rst         = 1'b1;
        ext_en      = 1'b0;
        ext_val     = '0;
        ifc.req     = '0;
        ifc.data_in = '0;
        model_reset();
        #1;
        check_eq("init_grant", 32'(ifc.grant), 32'd0);
        check_eq("init_oe", 32'(ifc.oe), 32'd0);
        check_eq("init_bus_q", 32'(ifc.bus_q), 32'd0);
        @(negedge clk);
        rst = 1'b0;

        // ch1 owns the bus driving A5, then reset strikes mid-burst.
        cyc(4'b0010, 32'h0000_A500, 1'b0, '0);
        check_eq("t1_bus", 32'(bus), 32'hA5);
        cyc(4'b0010, 32'h0000_A500, 1'b0, '0);
        do_reset();

        // Lone requester ch2: granted after one edge, bursts, then re-arbitrates.
        cyc(4'b0100, 32'h003C_0000, 1'b0, '0);
        check_eq("t2_grant", 32'(ifc.grant), 32'b0100);
        check_eq("t2_bus", 32'(bus), 32'h3C);
        for (int k = 0; k < 8; k++) cyc(4'b0100, 32'h003C_0000, 1'b0, '0);
        do_reset();

        // All channels requesting: rotation 0,1,2,3,0 with MAX_BURST cycles each.
        for (int k = 0; k < 20; k++) begin
            cyc(4'b1111, 32'h4433_2211, 1'b0, '0);
            exp_g = '0;
`ifdef BUS_TURNAROUND_EN
            if (k % (MAX_BURST + 1) != MAX_BURST) exp_g[(k / (MAX_BURST + 1)) % NCH] = 1'b1;
`else
            exp_g[(k / MAX_BURST) % NCH] = 1'b1;
`endif
            check_eq("t3_order", 32'(ifc.grant), 32'(exp_g));
        end
        do_reset();

        // ch3 drops after two cycles with ch0/ch1 pending: pointer wraps to ch0.
        cyc(4'b1000, 32'h7700_0000, 1'b0, '0);
        cyc(4'b1000, 32'h7700_0000, 1'b0, '0);
        cyc(4'b0011, 32'h0000_2211, 1'b0, '0);
`ifdef BUS_TURNAROUND_EN
        check_eq("t4_turn", 32'(ifc.grant), 32'd0);
        cyc(4'b0011, 32'h0000_2211, 1'b0, '0);
`endif
        check_eq("t4_wrap", 32'(ifc.grant), 32'b0001);
        do_reset();

        // Foreign driver while idle: sampled into bus_q, controller stays off.
        cyc(4'b0000, 32'h0, 1'b1, 8'h5A);
        check_eq("t5_oe", 32'(ifc.oe), 32'd0);
        check_eq("t5_bus_q", 32'(ifc.bus_q), 32'h5A);
        cyc(4'b0000, 32'h0, 1'b0, '0);
        do_reset();

        // Two requesters: ch0 burst, then ch1 (directly or after one gap cycle).
        for (int k = 0; k < MAX_BURST + 2; k++) begin
            cyc(4'b0011, 32'h0000_BBAA, 1'b0, '0);
            exp_g = (k < MAX_BURST) ? 4'b0001 : 4'b0010;
`ifdef BUS_TURNAROUND_EN
            if (k == MAX_BURST) exp_g = 4'b0000;
`endif
            check_eq("t6_handoff", 32'(ifc.grant), 32'(exp_g));
        end
        do_reset();

        // Random traffic with held requests and occasional foreign drivers.
        prev_r = '0;
        for (int i = 0; i < 500; i++) begin
            if ($urandom_range(0, 3) != 0) r = prev_r;
            else                           r = NCH'($urandom_range(0, (1 << NCH) - 1));
            d  = $urandom;
            xe = 1'b0;
            xv = WIDTH'($urandom);
            if (m_owner < 0 && $urandom_range(0, 4) == 0) begin
                r  = '0;
                xe = 1'b1;
            end
            cyc(r, d, xe, xv);
            prev_r = r;
        end
        cyc(4'b0000, 32'h0, 1'b0, '0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
